// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and types for the instruction-SRAM port-0 arbiter.
package imem_pkg;

    localparam int IMEM_WORDS          = 256;
    localparam int IMEM_WORD_ADDR_BITS = $clog2(IMEM_WORDS);
    localparam int IMEM_BYTE_ADDR_BITS = IMEM_WORD_ADDR_BITS + 2;

    typedef enum logic {
        ARB_BOOT,
        ARB_RUN
    } arb_state_e;

    // One slot of the fetch response pipeline.
    typedef struct packed {
        logic valid;
        logic err;
    } rsp_entry_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and SRAM port-0 signals shared by the arbiter and its neighbours.
interface imem_port_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                           fetch_valid_i;
    logic                           fetch_ready_o;
    logic [ADDR_WIDTH-1:0]          fetch_addr_i;
    logic                           fetch_rvalid_o;
    logic [31:0]                    fetch_rdata_o;
    logic                           fetch_err_o;

    logic                           load_valid_i;
    logic                           load_ready_o;
    logic [ADDR_WIDTH-1:0]          load_addr_i;
    logic [31:0]                    load_wdata_i;
    logic [3:0]                     load_wmask_i;
    logic                           load_done_i;
    logic                           load_err_o;

    logic                           sram_csb0_o;
    logic                           sram_web0_o;
    logic [3:0]                     sram_wmask0_o;
    logic [IMEM_WORD_ADDR_BITS-1:0] sram_addr0_o;
    logic [31:0]                    sram_din0_o;
    logic [31:0]                    sram_dout0_i;

    modport slave (
        input  fetch_valid_i, fetch_addr_i,
        input  load_valid_i, load_addr_i, load_wdata_i, load_wmask_i, load_done_i,
        input  sram_dout0_i,
        output fetch_ready_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        output load_ready_o, load_err_o,
        output sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o
    );

    modport master (
        output fetch_valid_i, fetch_addr_i,
        output load_valid_i, load_addr_i, load_wdata_i, load_wmask_i, load_done_i,
        output sram_dout0_i,
        input  fetch_ready_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        input  load_ready_o, load_err_o,
        input  sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o
    );

endinterface

// File: rtl/imem_port_arbiter_rsp_pipe.sv
// Two-stage fetch response pipeline: tracks valid/err and registers SRAM read data.
module imem_rsp_pipe
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  rsp_entry_t  req,
    input  logic [31:0] sram_dout,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata
);

    rsp_entry_t  s1_reg;
    rsp_entry_t  s2_reg;
    logic [31:0] rdata_reg;

    // Stage 1 lines up with the SRAM read cycle; faulting fetches return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= '0;
            s2_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            s1_reg    <= req;
            s2_reg    <= s1_reg;
            rdata_reg <= (s1_reg.valid && !s1_reg.err) ? sram_dout : '0;
        end
    end

    assign rsp_valid = s2_reg.valid;
    assign rsp_err   = s2_reg.err;
    assign rsp_rdata = rdata_reg;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares SRAM port 0 between instruction fetch and the program loader.
// Define IMEM_BOOT_HOLD_EN to start in BOOT and hold fetch until load_done_i.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int MAX_LOAD_BURST = 8,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_port_arbiter_if.slave  bus
);

    localparam int              CW        = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_LOAD_BURST);

    logic [CW-1:0] burst_cnt_reg;
    logic [CW-1:0] burst_cnt_next;
    logic          load_err_reg;
    logic          in_boot;
    logic          guard_trip;
    logic          load_grant;
    logic          fetch_grant;
    logic          fetch_fault;
    logic          load_in_range;
    rsp_entry_t    rsp_req;
    logic [1:0]    unused_load_lsb;

`ifdef IMEM_BOOT_HOLD_EN
    arb_state_e state_reg;
    arb_state_e state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ARB_BOOT;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ARB_BOOT && bus.load_done_i) state_next = ARB_RUN;
    end

    assign in_boot = (state_reg == ARB_BOOT);
`else
    logic unused_load_done;
    assign unused_load_done = bus.load_done_i;
    assign in_boot          = 1'b0;
`endif

    assign fetch_fault   = (bus.fetch_addr_i[1:0] != 2'b00) ||
                           (bus.fetch_addr_i[ADDR_WIDTH-1:IMEM_BYTE_ADDR_BITS] != '0);
    assign load_in_range = (bus.load_addr_i[ADDR_WIDTH-1:IMEM_BYTE_ADDR_BITS] == '0);
    // Byte lanes come only from the write mask.
    assign unused_load_lsb = bus.load_addr_i[1:0];

    // Readies are forced low while reset is held.
    assign guard_trip        = !in_boot && (burst_cnt_reg == BURST_MAX);
    assign bus.load_ready_o  = rst_n && !guard_trip;
    assign bus.fetch_ready_o = rst_n && !in_boot && !(bus.load_valid_i && !guard_trip);
    assign load_grant        = bus.load_valid_i && bus.load_ready_o;
    assign fetch_grant       = bus.fetch_valid_i && bus.fetch_ready_o;

    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (in_boot || fetch_grant || !bus.fetch_valid_i) burst_cnt_next = '0;
        else if (load_grant)                              burst_cnt_next = burst_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_reg <= '0;
            load_err_reg  <= 1'b0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
            if (load_grant && !load_in_range) load_err_reg <= 1'b1;
        end
    end

    // Faulting or out-of-range requests are accepted but leave the macro deselected.
    always_comb begin
        bus.sram_csb0_o   = 1'b1;
        bus.sram_web0_o   = 1'b1;
        bus.sram_wmask0_o = '0;
        bus.sram_addr0_o  = '0;
        bus.sram_din0_o   = '0;
        if (fetch_grant && !fetch_fault) begin
            bus.sram_csb0_o  = 1'b0;
            bus.sram_addr0_o = bus.fetch_addr_i[IMEM_BYTE_ADDR_BITS-1:2];
        end else if (load_grant && load_in_range) begin
            bus.sram_csb0_o   = 1'b0;
            bus.sram_web0_o   = 1'b0;
            bus.sram_wmask0_o = bus.load_wmask_i;
            bus.sram_addr0_o  = bus.load_addr_i[IMEM_BYTE_ADDR_BITS-1:2];
            bus.sram_din0_o   = bus.load_wdata_i;
        end
    end

    assign rsp_req.valid  = fetch_grant;
    assign rsp_req.err    = fetch_grant && fetch_fault;
    assign bus.load_err_o = load_err_reg;

    imem_rsp_pipe u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rsp_req),
        .sram_dout (bus.sram_dout0_i),
        .rsp_valid (bus.fetch_rvalid_o),
        .rsp_err   (bus.fetch_err_o),
        .rsp_rdata (bus.fetch_rdata_o)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with an SRAM port-0 model and a reference memory.
module tb_imem_port_arbiter;
    import imem_pkg::*;

    localparam int MAXB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc   = 0;

    imem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    imem_port_arbiter #(.MAX_LOAD_BURST(MAXB), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro port 0: synchronous read/write on the rising edge.
    logic [31:0] sram_mem [256];
    logic [31:0] sram_dout = '0;
    assign bus.sram_dout0_i = sram_dout;

    always @(posedge clk) begin
        if (!bus.sram_csb0_o) begin
            if (!bus.sram_web0_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wmask0_o[b])
                        sram_mem[bus.sram_addr0_o][8*b +: 8] <= bus.sram_din0_o[8*b +: 8];
            end else begin
                sram_dout <= sram_mem[bus.sram_addr0_o];
            end
        end
    end

    // Reference memory as seen by the loader's accepted writes.
    logic [31:0] ref_mem [256];

    function automatic void ref_write(logic [31:0] a, logic [31:0] d, logic [3:0] m);
        if (a < 32'h400)
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic ref_fault(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.fetch_valid_i = 1'b0;
        bus.fetch_addr_i  = '0;
        bus.load_valid_i  = 1'b0;
        bus.load_addr_i   = '0;
        bus.load_wdata_i  = '0;
        bus.load_wmask_i  = '0;
        bus.load_done_i   = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rvalid"}, bus.fetch_rvalid_o, 0);
        chk({tag, "_rdata"},  bus.fetch_rdata_o, 0);
        chk({tag, "_err"},    bus.fetch_err_o, 0);
        chk({tag, "_loaderr"}, bus.load_err_o, 0);
        chk({tag, "_csb"},    bus.sram_csb0_o, 1);
        chk({tag, "_web"},    bus.sram_web0_o, 1);
        chk({tag, "_wmask"},  bus.sram_wmask0_o, 0);
        chk({tag, "_addr"},   bus.sram_addr0_o, 0);
        chk({tag, "_din"},    bus.sram_din0_o, 0);
        $display("reset check %s at cycle %0d", tag, cyc);
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.load_valid_i = 1'b1;
        bus.load_addr_i  = a;
        bus.load_wdata_i = d;
        bus.load_wmask_i = m;
        #2;
        chk("load_ready", bus.load_ready_o, 1);
        chk("load_csb", bus.sram_csb0_o, (a >= 32'h400));
        ref_write(a, d, m);
        $display("load  addr=%h data=%h mask=%b", a, d, m);
        step();
        bus.load_valid_i = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] a, input logic e, input logic [31:0] d);
        bus.fetch_valid_i = 1'b1;
        bus.fetch_addr_i  = a;
        #2;
        chk("fetch_ready", bus.fetch_ready_o, 1);
        chk("fetch_csb", bus.sram_csb0_o, e);
        if (!e) chk("fetch_sram_addr", bus.sram_addr0_o, a[9:2]);
        step();
        bus.fetch_valid_i = 1'b0;
        #2;
        chk("rvalid_early", bus.fetch_rvalid_o, 0);
        step();
        #2;
        chk("rvalid", bus.fetch_rvalid_o, 1);
        chk("rdata", bus.fetch_rdata_o, d);
        chk("rerr", bus.fetch_err_o, e);
        $display("fetch addr=%h rdata=%h err=%b", a, bus.fetch_rdata_o, bus.fetch_err_o);
        step();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs [10];
    rsp_t        q [$];
    logic [31:0] b2b_exp [3];

    task automatic rsp_check(input string tag);
        rsp_t e;
        logic exp_rv;
        exp_rv = (q.size() > 0) && (q[0].due == cyc);
        chk({tag, "_rvalid"}, bus.fetch_rvalid_o, exp_rv);
        if (exp_rv) begin
            e = q.pop_front();
            chk({tag, "_rdata"}, bus.fetch_rdata_o, e.data);
            chk({tag, "_err"}, bus.fetch_err_o, e.err);
            $display("rsp   cyc=%0d rdata=%h err=%b", cyc, bus.fetch_rdata_o, bus.fetch_err_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          streak;
        logic        fv, lv, el, ef, flt;
        logic [31:0] fa, la, wd;
        logic [3:0]  wm;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_000A};
        vecs[1] = '{32'h0000_0004, 1'b0, 32'h0000_000B};
        vecs[2] = '{32'h0000_0008, 1'b0, 32'h0000_000C};
        vecs[3] = '{32'h0000_0010, 1'b0, 32'hFF00_FF00};
        vecs[4] = '{32'h0000_0020, 1'b0, 32'h0000_0055};
        vecs[5] = '{32'h0000_03FC, 1'b0, 32'h1234_5678};
        vecs[6] = '{32'h0000_0002, 1'b1, 32'h0000_0000};
        vecs[7] = '{32'h0000_0007, 1'b1, 32'h0000_0000};
        vecs[8] = '{32'h0000_0400, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'h8000_0000, 1'b1, 32'h0000_0000};
        b2b_exp[0] = 32'hA;
        b2b_exp[1] = 32'hB;
        b2b_exp[2] = 32'hC;

        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        // Reset with both requesters asking: nothing may be accepted.
        drive_idle();
        bus.fetch_valid_i = 1'b1;
        bus.load_valid_i  = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_fetch_ready", bus.fetch_ready_o, 0);
        chk("rst_load_ready", bus.load_ready_o, 0);
        reset_check("por");
        drive_idle();
        step();
        rst_n = 1'b1;
        step();

`ifdef IMEM_BOOT_HOLD_EN
        bus.fetch_valid_i = 1'b1;
        bus.fetch_addr_i  = '0;
        #2;
        chk("boot_fetch_ready", bus.fetch_ready_o, 0);
        step();
        bus.fetch_valid_i = 1'b0;
        bus.load_done_i   = 1'b1;
        load_word(32'h0, 32'h0000_0013, 4'hF);
        bus.load_done_i   = 1'b0;
`else
        load_word(32'h0, 32'h0000_0013, 4'hF);
`endif
        fetch_one(32'h0, 1'b0, 32'h0000_0013);

        load_word(32'h0,   32'hA, 4'hF);
        load_word(32'h4,   32'hB, 4'hF);
        load_word(32'h8,   32'hC, 4'hF);
        load_word(32'h3FC, 32'h1234_5678, 4'hF);
        load_word(32'h10,  32'hFFFF_FFFF, 4'hF);
        load_word(32'h10,  32'h0000_0000, 4'b0101);
        load_word(32'h21,  32'h0000_0055, 4'hF);
        chk("load_err_clear", bus.load_err_o, 0);
        load_word(32'h400, 32'hDEAD_BEEF, 4'hF);
        chk("load_err_set", bus.load_err_o, 1);

        // Back-to-back fetches: responses two cycles later, in order, no gaps.
        for (int i = 0; i < 6; i++) begin
            bus.fetch_valid_i = (i < 3);
            bus.fetch_addr_i  = 32'(4 * i);
            #2;
            if (i < 3) chk("b2b_ready", bus.fetch_ready_o, 1);
            chk("b2b_rvalid", bus.fetch_rvalid_o, (i >= 2 && i < 5));
            if (i >= 2 && i < 5) begin
                chk("b2b_rdata", bus.fetch_rdata_o, b2b_exp[i-2]);
                $display("b2b   rsp %0d rdata=%h", i - 2, bus.fetch_rdata_o);
            end
            step();
        end
        drive_idle();

        for (int i = 0; i < 10; i++)
            fetch_one(vecs[i].addr, vecs[i].err, vecs[i].data);

        // Both requesters saturated: eight loader grants then one fetch grant.
        bus.fetch_valid_i = 1'b1;
        bus.fetch_addr_i  = 32'h40;
        bus.load_valid_i  = 1'b1;
        bus.load_wmask_i  = 4'hF;
        for (int i = 0; i < 27; i++) begin
            bus.load_addr_i  = 32'h300 + 32'(4 * i);
            bus.load_wdata_i = 32'(i);
            #2;
            el = ((i % 9) != 8);
            chk("starve_load_ready", bus.load_ready_o, el);
            chk("starve_fetch_ready", bus.fetch_ready_o, !el);
            if (el) ref_write(bus.load_addr_i, bus.load_wdata_i, 4'hF);
            $display("starve %0d grant=%s", i, el ? "load" : "fetch");
            step();
        end
        drive_idle();
        repeat (3) step();

        // Random traffic against the reference model.
        streak = 0;
        q.delete();
        for (int i = 0; i < 300; i++) begin
            fv = ($urandom_range(0, 9) < 7);
            lv = ($urandom_range(0, 9) < 5);
            case ($urandom_range(0, 19))
                0:       fa = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                1:       fa = 32'h400 + 32'($urandom_range(0, 1023) * 4);
                default: fa = 32'($urandom_range(0, 31) * 4);
            endcase
            la = ($urandom_range(0, 29) == 0) ? 32'h800 : 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            bus.fetch_valid_i = fv;
            bus.fetch_addr_i  = fa;
            bus.load_valid_i  = lv;
            bus.load_addr_i   = la;
            bus.load_wdata_i  = wd;
            bus.load_wmask_i  = wm;
            #2;
            el  = lv && (streak < MAXB);
            ef  = fv && !el;
            flt = ref_fault(fa);
            if (lv) chk("rnd_load_ready", bus.load_ready_o, (streak < MAXB));
            if (fv) chk("rnd_fetch_ready", bus.fetch_ready_o, !el);
            chk("rnd_csb", bus.sram_csb0_o, !((ef && !flt) || (el && la < 32'h400)));
            rsp_check("rnd");
            if (ef) begin
                q.push_back('{cyc + 2, flt, flt ? 32'h0 : ref_mem[fa[9:2]]});
                $display("rnd   cyc=%0d fetch addr=%h", cyc, fa);
            end
            if (el) begin
                ref_write(la, wd, wm);
                $display("rnd   cyc=%0d load  addr=%h data=%h mask=%b", cyc, la, wd, wm);
            end
            streak = (ef || !fv) ? 0 : (el ? streak + 1 : streak);
            step();
        end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            rsp_check("drain");
            step();
        end
        chk("drain_empty", q.size(), 0);
        chk("load_err_sticky", bus.load_err_o, 1);

        // Reset one cycle after a fetch grant must flush the response.
        bus.fetch_valid_i = 1'b1;
        bus.fetch_addr_i  = 32'h4;
        #2;
        chk("flush_grant", bus.fetch_ready_o, 1);
        step();
        bus.load_valid_i = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("flush_fetch_ready", bus.fetch_ready_o, 0);
        chk("flush_load_ready", bus.load_ready_o, 0);
        reset_check("midrst");
        step();
        drive_idle();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("flush_no_rvalid", bus.fetch_rvalid_o, 0);
            step();
        end
        reset_check("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequences port 0 (RW) of the 256×32 instruction SRAM macro `sram_1rw1r_32_256_8_sky130` and shares it between two requesters: core instruction fetch (read) and the program loader (write). It sits between the fetch stage / loader and the SRAM macro, replacing direct tie-offs of `csb0`/`web0`/`wmask0`/`din0`. It provides fixed-latency read responses, loader-priority arbitration with a fetch starvation guard, and address checking.

## Interface
- `MAX_LOAD_BURST`, 8: maximum consecutive loader grants while a fetch is waiting.
- `ADDR_WIDTH`, 32: byte-address width of both requesters.
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `fetch_valid_i` in 1, `fetch_ready_o` out 1, `fetch_addr_i` in ADDR_WIDTH: fetch request, byte address.
- `fetch_rvalid_o` out 1, `fetch_rdata_o` out 32, `fetch_err_o` out 1: fetch response. There is no response backpressure.
- `load_valid_i` in 1, `load_ready_o` out 1, `load_addr_i` in ADDR_WIDTH, `load_wdata_i` in 32, `load_wmask_i` in 4: loader write request.
- `load_done_i` in 1: one-cycle pulse marking the end of program load.
- `load_err_o` out 1: sticky flag, set by an out-of-range loader write.
- `sram_csb0_o` out 1, `sram_web0_o` out 1, `sram_wmask0_o` out 4, `sram_addr0_o` out 8, `sram_din0_o` out 32: SRAM port-0 controls.
- `sram_dout0_i` in 32: SRAM port-0 read data.

## Operation
- **Address checks:**
  - SRAM word address = `addr[9:2]`.
  - In range means `addr[ADDR_WIDTH-1:10] == 0`.
  - A fetch is misaligned when `addr[1:0] != 0`.
- **Arbitration, evaluated combinationally each cycle, state RUN:**
  - If the loader is valid and the guard is not tripped, the loader is granted: `load_ready_o=1`, `fetch_ready_o=0`.
  - Otherwise, a valid fetch is granted.
- **Starvation guard:**
  - Counter `burst_cnt` (width `$clog2(MAX_LOAD_BURST+1)`) increments on each loader grant made while `fetch_valid_i=1`.
  - It clears on any fetch grant, or in any cycle with `fetch_valid_i=0`.
  - When `burst_cnt==MAX_LOAD_BURST`, the guard trips: the fetch gets the next grant and the loader sees `load_ready_o=0`.
- **SRAM drive on a grant:**
  - Fetch grant: `csb0=0`, `web0=1`.
  - Loader grant: `csb0=0`, `web0=0`, `wmask0=load_wmask_i`, `din0=load_wdata_i`.
  - No grant: `csb0=1`, `web0=1`, `wmask0=0`, `addr0=0`, `din0=0`.
- **Faulting fetch** (misaligned or out of range):
  - Accepted with `csb0=1`.
  - Response carries `fetch_err_o=1` and `fetch_rdata_o=0`.
- **Out-of-range loader write:**
  - Accepted (`load_ready_o=1`), `csb0=1`, write dropped.
  - `load_err_o` is set and stays set until reset.
- **Loader address bits:** `load_addr_i[1:0]` is ignored; byte lanes are selected only by `load_wmask_i`.
- **States:** BOOT and RUN.
  - In BOOT, `fetch_ready_o=0` and only loader writes are granted; the guard is inactive.
  - BOOT→RUN on `load_done_i=1`.
  - RUN has no exit except reset.
  - `load_done_i` in RUN is ignored.

## Timing
- Requests are accepted on back-to-back cycles with no bubbles; at most one grant per cycle.
- Fetch accepted in cycle C → `fetch_rvalid_o=1` in cycle C+2 with data or error. The SRAM captures at the end of C, and the controller registers `sram_dout0_i` at the end of C+1.
- Up to two fetch responses are in flight. Responses return in order, one per cycle, with no gaps added.
- Loader write accepted in cycle C → SRAM updated at the end of C. A fetch to the same word accepted in C+1 or later returns the new data.
- **Reset values:**
  - `fetch_rvalid_o=0`, `fetch_rdata_o=0`, `fetch_err_o=0`, `load_err_o=0`.
  - `sram_csb0_o=1`, `sram_web0_o=1`, `sram_wmask0_o=0`, `sram_addr0_o=0`, `sram_din0_o=0`.
  - `burst_cnt=0`.
- While `rst_n=0`: `fetch_ready_o=0` and `load_ready_o=0`.
- Reset asserted mid-operation flushes in-flight responses; no `fetch_rvalid_o` is emitted after reset deasserts.
- Both requesters valid in the same cycle in RUN: the loader wins unless the guard has tripped.
- `load_done_i` asserted together with a loader request in BOOT: the write is granted, and RUN applies from the next cycle.

## Configuration
- `IMEM_BOOT_HOLD_EN` defined: reset state is BOOT and fetch is held until `load_done_i`.
- `IMEM_BOOT_HOLD_EN` undefined: reset state is RUN. BOOT logic is removed, `load_done_i` is unused, and fetch is grantable in the first cycle after reset.

## Structure
- **Package `imem_pkg`:**
  - `IMEM_WORDS=256`, `IMEM_WORD_ADDR_BITS=8`, `IMEM_BYTE_ADDR_BITS=10`.
  - `typedef enum logic {ARB_BOOT, ARB_RUN} arb_state_e`.
  - `typedef struct` for the response-pipeline entry: `valid`, `err`.
- **Sub-module `imem_rsp_pipe`:** 2-stage response pipeline carrying valid/err and registering `sram_dout0_i`. The top level holds the FSM, the guard counter, address checks and SRAM muxing.

## Test plan
- **Reset/boot:** with `IMEM_BOOT_HOLD_EN` defined, after reset `fetch_valid_i=1` gives `fetch_ready_o=0`. Loader writes 0x00000013 at 0x0 with mask 4'hF, then `load_done_i` pulses. The fetch of 0x0 is then granted and returns rdata=0x00000013 exactly 2 cycles after grant.
- **Back-to-back fetch:** words 0x0/0x4/0x8 are preloaded with 0xA, 0xB and 0xC. Fetch requests in cycles 10, 11, 12 produce rvalid in cycles 12, 13, 14 with data in the same order.
- **Arbitration/starvation:** with `MAX_LOAD_BURST=8`, loader and fetch are both valid continuously. The pattern is 8 loader grants, 1 fetch grant, repeating.
- **Faults:**
  - Fetch at 0x2 → err=1, rdata=0, `csb0=1`.
  - Fetch at 0x400 → err=1.
  - Loader write at 0x400 → `load_err_o=1` stays set, and memory is unchanged.
- **Byte mask:** word 0x10 is written 0xFFFFFFFF, then written 0x00000000 with mask 4'b0101. A fetch of 0x10 returns 0xFF00FF00.
- **Reset mid-flight:** assert `rst_n=0` one cycle after a fetch grant. No rvalid appears afterwards and all outputs hold their reset values.
